// File: rtl/libv_queue_issue_pkg.sv
// Shared types for the speculative issue stage: FSM state encoding and the
// helper that sizes the outstanding-entry counter.
package libv_queue_issue_pkg;

    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        DRAIN  = 2'd1,
        REPLAY = 2'd2
    } state_t;

    // Width needed to hold 0..max_inflight inclusive.
    function automatic int inflight_w(input int max_inflight);
        return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
    endfunction

endpackage

// File: rtl/libv_watchdog.sv
// Reloadable down-counter: expired is high on the PERIOD-th consecutive cycle
// without reload. Used by libv_queue_issue when LIBV_QUEUE_ISSUE_TIMEOUT_EN is defined.
module libv_watchdog #(
    parameter int PERIOD = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic expired
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        expired = !reload && (cnt_q == '0);
        cnt_d   = cnt_q;
        if (reload || expired) begin
            cnt_d = LOAD;
        end else begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/libv_queue_issue.sv
// Speculative issue stage between a replayable queue and a valid/accept link.
// Optional response timeout enabled by defining LIBV_QUEUE_ISSUE_TIMEOUT_EN.
module libv_queue_issue
    import libv_queue_issue_pkg::*;
#(
    parameter int W            = 32,
    parameter int MAX_INFLIGHT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 q_empty_w,
    input  logic [W-1:0]                         q_data,
    output logic                                 q_pop,
    output logic                                 q_commit,
    output logic                                 q_replay,
    output logic                                 q_flush,
    input  logic                                 flush,
    output logic                                 out_vld,
    output logic [W-1:0]                         out_data,
    input  logic                                 out_accept,
    input  logic                                 rsp_vld,
    input  logic                                 rsp_ack,
    output logic                                 link_abort,
    output logic [inflight_w(MAX_INFLIGHT)-1:0]  inflight,
    output logic                                 rsp_err
);

    localparam int IW = inflight_w(MAX_INFLIGHT);
    localparam logic [IW-1:0] MAX_CNT = IW'(MAX_INFLIGHT);

    if (MAX_INFLIGHT < 1 || TIMEOUT < 1) begin : g_bad_params
        $error("libv_queue_issue: MAX_INFLIGHT and TIMEOUT must be at least 1");
    end

    state_t        state_q, state_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          empty_r_q, empty_r_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_take;
    logic          force_replay;

`ifdef LIBV_QUEUE_ISSUE_TIMEOUT_EN
    logic wd_reload;
    logic wd_expired;

    // Silence only accumulates while something is outstanding and the link is quiet.
    assign wd_reload = flush | rsp_vld | (inflight_q == '0);

    libv_watchdog #(
        .PERIOD (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .reload  (wd_reload),
        .expired (wd_expired)
    );

    assign force_replay = wd_expired && (state_q != REPLAY);
`else
    assign force_replay = 1'b0;
`endif

    assign empty_r_d = q_empty_w;
    assign q_flush   = flush;
    assign out_data  = q_data;
    assign inflight  = inflight_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d    = state_q;
        inflight_d = inflight_q;
        rsp_err_d  = rsp_err_q;
        out_vld    = 1'b0;
        q_pop      = 1'b0;
        q_commit   = 1'b0;
        q_replay   = 1'b0;
        link_abort = 1'b0;
        rsp_take   = rsp_vld && (inflight_q != '0);

        if (flush) begin
            link_abort = (inflight_q != '0);
            inflight_d = '0;
            state_d    = ISSUE;
        end else if (force_replay) begin
            link_abort = 1'b1;
            inflight_d = '0;
            state_d    = REPLAY;
        end else begin
            if (rsp_vld && (inflight_q == '0)) begin
                rsp_err_d = 1'b1;
            end
            unique case (state_q)
                ISSUE: begin
                    out_vld    = !empty_r_q && (inflight_q < MAX_CNT);
                    q_pop      = out_vld && out_accept;
                    inflight_d = inflight_q + IW'(q_pop) - IW'(rsp_take);
                    if (rsp_take) begin
                        if (rsp_ack) begin
                            q_commit = 1'b1;
                        end else if (inflight_d == '0) begin
                            state_d = REPLAY;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
                // Entries after a NACK cannot commit: the architectural pointer is in order.
                DRAIN: begin
                    inflight_d = inflight_q - IW'(rsp_take);
                    if (inflight_d == '0) begin
                        state_d = REPLAY;
                    end
                end
                REPLAY: begin
                    q_replay = 1'b1;
                    state_d  = ISSUE;
                end
                default: begin
                    state_d = ISSUE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ISSUE;
            inflight_q <= '0;
            empty_r_q  <= 1'b1;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            empty_r_q  <= empty_r_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

`ifndef SYNTHESIS
    a_no_commit_with_replay: assert property (@(posedge clk) disable iff (rst)
        !(q_commit && q_replay));
    a_inflight_bound: assert property (@(posedge clk) disable iff (rst)
        inflight_q <= MAX_CNT);
`endif

endmodule

// File: tb/tb_libv_queue_issue.sv
// Bench for libv_queue_issue: directed vector table, async reset, optional
// timeout sequence, then randomized traffic against a pointer/count model.
module tb_libv_queue_issue;

    localparam int W    = 32;
    localparam int MAXI = 4;
    localparam int IW   = $clog2(MAXI + 1);
`ifdef LIBV_QUEUE_ISSUE_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 64;
`endif

    localparam logic [W-1:0] D_A = 32'hA1, D_B = 32'hB2, D_C = 32'hC3;
    localparam logic [W-1:0] D_D = 32'hD4, D_E = 32'hE5, D_F = 32'hF6;
    localparam logic [W-1:0] G1 = 32'h11, G2 = 32'h12, G3 = 32'h13;
    localparam logic [W-1:0] G4 = 32'h14, G5 = 32'h15, G6 = 32'h16;

    logic          clk = 1'b0;
    logic          rst;
    logic          q_empty_w;
    logic [W-1:0]  q_data;
    logic          q_pop, q_commit, q_replay, q_flush;
    logic          flush;
    logic          out_vld;
    logic [W-1:0]  out_data;
    logic          out_accept, rsp_vld, rsp_ack;
    logic          link_abort;
    logic [IW-1:0] inflight;
    logic          rsp_err;
    logic          push;
    logic [W-1:0]  push_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    libv_queue_issue #(
        .W            (W),
        .MAX_INFLIGHT (MAXI),
        .TIMEOUT      (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q_empty_w  (q_empty_w),
        .q_data     (q_data),
        .q_pop      (q_pop),
        .q_commit   (q_commit),
        .q_replay   (q_replay),
        .q_flush    (q_flush),
        .flush      (flush),
        .out_vld    (out_vld),
        .out_data   (out_data),
        .out_accept (out_accept),
        .rsp_vld    (rsp_vld),
        .rsp_ack    (rsp_ack),
        .link_abort (link_abort),
        .inflight   (inflight),
        .rsp_err    (rsp_err)
    );

    // Replayable queue environment: speculative, architectural and write pointers.
    logic [W-1:0] mem [0:4095];
    int wr_q = 0, spec_q = 0, arch_q = 0;
    int wr_n, spec_n, arch_n;

    always_comb begin
        wr_n   = wr_q;
        spec_n = spec_q;
        arch_n = arch_q;
        if (flush) begin
            wr_n   = 0;
            spec_n = 0;
            arch_n = 0;
        end else begin
            if (push) wr_n = wr_q + 1;
            if (q_replay) spec_n = arch_q;
            else if (q_pop) spec_n = spec_q + 1;
            if (q_commit) arch_n = arch_q + 1;
        end
    end

    assign q_empty_w = (wr_n == spec_n);
    assign q_data    = mem[spec_q[11:0]];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 0;
            spec_q <= 0;
            arch_q <= 0;
        end else begin
            if (push && !flush) mem[wr_q[11:0]] <= push_data;
            wr_q   <= wr_n;
            spec_q <= spec_n;
            arch_q <= arch_n;
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         push;
        logic [W-1:0] pdata;
        logic         acc;
        logic         rv;
        logic         ra;
        logic         fl;
        logic         e_vld;
        logic [W-1:0] e_data;
        logic         e_pop;
        logic         e_commit;
        logic         e_replay;
        logic         e_abort;
        int           e_infl;
        logic         e_err;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic [W-1:0] pd, input logic a,
                                input logic rv, input logic ra, input logic fl,
                                input logic v, input logic [W-1:0] d, input logic pop,
                                input logic cm, input logic rp, input logic ab,
                                input int n, input logic er);
        vec_t t;
        t.push = p;   t.pdata = pd;  t.acc = a;      t.rv = rv;       t.ra = ra;
        t.fl = fl;    t.e_vld = v;   t.e_data = d;   t.e_pop = pop;   t.e_commit = cm;
        t.e_replay = rp; t.e_abort = ab; t.e_infl = n; t.e_err = er;
        return t;
    endfunction

    vec_t vecs[$];

    // Behavioural model state: counts and pointers only.
    localparam int M_ISSUE = 0, M_DRAIN = 1, M_REPLAY = 2;
    int           m_out, m_mode, m_spec, m_arch, m_wr;
    bit           m_err, m_empty_vis, take;
    logic [W-1:0] m_data [0:4095];
    logic         e_vld, e_pop, e_commit, e_replay, e_abort;

    task automatic idle_inputs();
        push = 1'b0; push_data = '0; out_accept = 1'b0;
        rsp_vld = 1'b0; rsp_ack = 1'b0; flush = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        idle_inputs();
        rst = 1'b1;

        //         push pdata acc rv ra fl | vld data pop cm rp ab infl err
        vecs.push_back(mk(1, D_A, 1, 0, 0, 0,  0, '0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, D_B, 1, 0, 0, 0,  1, D_A, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, D_C, 1, 0, 0, 0,  1, D_B, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, '0,  1, 1, 1, 0,  1, D_C, 1, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, '0,  1, 1, 1, 0,  0, '0,  0, 1, 0, 0, 2, 0));
        vecs.push_back(mk(0, '0,  1, 1, 1, 0,  0, '0,  0, 1, 0, 0, 1, 0));
        vecs.push_back(mk(1, D_D, 1, 0, 0, 0,  0, '0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, D_E, 1, 0, 0, 0,  1, D_D, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, D_F, 1, 0, 0, 0,  1, D_E, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  1, D_F, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, '0,  1, 1, 0, 0,  0, '0,  0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, '0,  1, 1, 1, 0,  0, '0,  0, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, '0,  1, 1, 1, 0,  0, '0,  0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  0, '0,  0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  1, D_D, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  1, D_E, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  1, D_F, 1, 0, 0, 0, 2, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  0, '0,  0, 0, 0, 0, 3, 0));
        vecs.push_back(mk(0, '0,  1, 0, 0, 1,  0, '0,  0, 0, 0, 1, 3, 0));
        vecs.push_back(mk(0, '0,  1, 1, 1, 0,  0, '0,  0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, G1,  1, 0, 0, 0,  0, '0,  0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, G2,  1, 0, 0, 0,  1, G1,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, G3,  1, 0, 0, 0,  1, G2,  1, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, G4,  1, 0, 0, 0,  1, G3,  1, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, G5,  1, 0, 0, 0,  1, G4,  1, 0, 0, 0, 3, 1));
        vecs.push_back(mk(1, G6,  1, 0, 0, 0,  0, '0,  0, 0, 0, 0, 4, 1));
        vecs.push_back(mk(0, '0,  1, 0, 0, 0,  0, '0,  0, 0, 0, 0, 4, 1));

        repeat (2) @(negedge clk);
        check("reset out_vld", out_vld, 1'b0);
        check("reset q_pop", q_pop, 1'b0);
        check("reset q_commit", q_commit, 1'b0);
        check("reset q_replay", q_replay, 1'b0);
        check("reset link_abort", link_abort, 1'b0);
        check("reset inflight", inflight, '0);
        check("reset rsp_err", rsp_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            push = vecs[i].push;  push_data = vecs[i].pdata; out_accept = vecs[i].acc;
            rsp_vld = vecs[i].rv; rsp_ack = vecs[i].ra;      flush = vecs[i].fl;
            #1;
            check($sformatf("v%0d out_vld", i), out_vld, vecs[i].e_vld);
            if (vecs[i].e_vld) check($sformatf("v%0d out_data", i), out_data, vecs[i].e_data);
            check($sformatf("v%0d q_pop", i), q_pop, vecs[i].e_pop);
            check($sformatf("v%0d q_commit", i), q_commit, vecs[i].e_commit);
            check($sformatf("v%0d q_replay", i), q_replay, vecs[i].e_replay);
            check($sformatf("v%0d link_abort", i), link_abort, vecs[i].e_abort);
            check($sformatf("v%0d q_flush", i), q_flush, vecs[i].fl);
            check($sformatf("v%0d inflight", i), inflight, W'(vecs[i].e_infl));
            check($sformatf("v%0d rsp_err", i), rsp_err, vecs[i].e_err);
        end

        // Asynchronous reset while four entries are outstanding and rsp_err is set.
        @(negedge clk);
        idle_inputs();
        #2 rst = 1'b1;
        #1;
        check("async_rst inflight", inflight, '0);
        check("async_rst rsp_err", rsp_err, 1'b0);
        check("async_rst out_vld", out_vld, 1'b0);
        check("async_rst link_abort", link_abort, 1'b0);
        @(negedge clk);
        rst = 1'b0;

`ifdef LIBV_QUEUE_ISSUE_TIMEOUT_EN
        begin
            int silent;
            bit seen;
            silent = 0;
            seen = 1'b0;
            @(negedge clk);
            push = 1'b1; push_data = D_A; out_accept = 1'b1;
            @(negedge clk);
            push = 1'b0;
            #1;
            check("to first issue", out_data, D_A);
            for (int k = 1; k <= 20 && !seen; k++) begin
                @(negedge clk);
                #1;
                if (link_abort) begin
                    seen = 1'b1;
                    silent = k;
                end
            end
            check("to link_abort seen", seen, 1'b1);
            check("to silent cycles", W'(silent), W'(8));
            @(negedge clk);
            #1;
            check("to q_replay", q_replay, 1'b1);
            @(negedge clk);
            #1;
            check("to reissue vld", out_vld, 1'b1);
            check("to reissue data", out_data, D_A);
            idle_inputs();
        end
`else
        @(negedge clk);
        m_out = 0; m_mode = M_ISSUE; m_spec = 0; m_arch = 0; m_wr = 0;
        m_err = 1'b0; m_empty_vis = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            flush      = ($urandom_range(0, 96) == 0);
            push       = !flush && ($urandom_range(0, 2) == 0) && (m_wr < 4000);
            push_data  = $urandom;
            out_accept = ($urandom_range(0, 3) != 0);
            rsp_vld    = (m_out > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            rsp_ack    = ($urandom_range(0, 4) != 0);
            #1;
            take = rsp_vld && (m_out > 0);
            e_vld = 1'b0; e_pop = 1'b0; e_commit = 1'b0; e_replay = 1'b0; e_abort = 1'b0;
            if (flush) begin
                e_abort = (m_out > 0);
            end else if (m_mode == M_ISSUE) begin
                e_vld    = !m_empty_vis && (m_out < MAXI);
                e_pop    = e_vld && out_accept;
                e_commit = take && rsp_ack;
            end else if (m_mode == M_REPLAY) begin
                e_replay = 1'b1;
            end
            check($sformatf("rnd%0d out_vld", cyc), out_vld, e_vld);
            if (e_vld) check($sformatf("rnd%0d out_data", cyc), out_data, m_data[m_spec]);
            check($sformatf("rnd%0d q_pop", cyc), q_pop, e_pop);
            check($sformatf("rnd%0d q_commit", cyc), q_commit, e_commit);
            check($sformatf("rnd%0d q_replay", cyc), q_replay, e_replay);
            check($sformatf("rnd%0d link_abort", cyc), link_abort, e_abort);
            check($sformatf("rnd%0d inflight", cyc), inflight, W'(m_out));
            check($sformatf("rnd%0d rsp_err", cyc), rsp_err, m_err);
            @(posedge clk);
            if (flush) begin
                m_out = 0; m_mode = M_ISSUE; m_wr = 0; m_spec = 0; m_arch = 0;
            end else begin
                if (rsp_vld && m_out == 0) m_err = 1'b1;
                case (m_mode)
                    M_ISSUE: begin
                        if (e_pop) begin
                            m_spec++;
                            m_out++;
                        end
                        if (take) begin
                            m_out--;
                            if (rsp_ack) m_arch++;
                            else m_mode = (m_out == 0) ? M_REPLAY : M_DRAIN;
                        end
                    end
                    M_DRAIN: begin
                        if (take) m_out--;
                        if (m_out == 0) m_mode = M_REPLAY;
                    end
                    default: begin
                        m_spec = m_arch;
                        m_mode = M_ISSUE;
                    end
                endcase
                if (push) begin
                    m_data[m_wr] = push_data;
                    m_wr++;
                end
            end
            m_empty_vis = (m_wr == m_spec);
        end
        idle_inputs();
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
